// File: rtl/queue_xfer_pkg.sv
// Shared types and sizing helpers for the deserializer-to-queue transfer controller.
package queue_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENQ  = 2'd1,
        ACK  = 2'd2,
        DEQ  = 2'd3
    } xfer_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_xfer_ctrl_rise_detect.sv
// Single-register rising-edge detector; the history register clears on reset so a
// level already high when reset releases is reported as one fresh edge.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/queue_xfer_ctrl.sv
// Sequences deserializer bytes into the byte queue with a four-phase ready/ack
// handshake, arbitrates user dequeues and tracks occupancy locally.
module queue_xfer_ctrl
    import queue_xfer_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      data_ready_in,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      ack_out,
    output logic                      space_out,
    input  logic                      dequeue_req_in,
    output logic                      enqueue_out,
    output logic                      dequeue_out,
    output logic [DATA_W-1:0]         queue_data_out,
    output logic [cnt_w(DEPTH)-1:0]   count_out,
    output logic                      underflow_err,
    output logic                      timeout_err
);

    localparam int CW = cnt_w(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    xfer_state_t       state;
    logic [DATA_W-1:0] data_reg;
    logic [CW-1:0]     count;
    logic              space;
    logic              pending;
    logic              rearm;
    logic              underflow;
    logic              timeout;
    logic [TW-1:0]     tcnt;
    logic              dq_rise;
    logic              enq_ok;
    logic              deq_ok;
    logic              pending_clr;
    logic              ack_expire;

    rise_detect u_rise_detect (
        .clock (clock),
        .reset (reset),
        .sig   (dequeue_req_in),
        .rise  (dq_rise)
    );

    // rearm blocks re-capture of a byte whose handshake timed out until ready drops
    assign enq_ok      = data_ready_in && !rearm && (count != FULL);
    assign deq_ok      = pending && (count != '0);
    assign pending_clr = (state == DEQ) || (state == IDLE && pending && count == '0);
    assign ack_expire  = (state == ACK) && data_ready_in && (tcnt == T_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            data_reg  <= '0;
            count     <= '0;
            space     <= 1'b1;
            pending   <= 1'b0;
            rearm     <= 1'b0;
            underflow <= 1'b0;
            timeout   <= 1'b0;
            tcnt      <= '0;
        end else begin
            pending <= pending_clr ? 1'b0 : (pending | dq_rise);

            if (ack_expire) begin
                rearm <= 1'b1;
            end else if (!data_ready_in) begin
                rearm <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // near-full favours a dequeue so a waiting byte is not starved twice
                    if (pending && count == '0) begin
                        underflow <= 1'b1;
                    end else if (enq_ok && (!deq_ok || count != ALMOST)) begin
                        data_reg <= data_in;
                        state    <= ENQ;
                    end else if (deq_ok) begin
                        state <= DEQ;
                    end
                end
                ENQ: begin
                    count <= count + CW'(1);
                    space <= (count != ALMOST);
                    tcnt  <= '0;
                    state <= ACK;
                end
                ACK: begin
                    if (!data_ready_in) begin
                        state <= IDLE;
                    end else if (tcnt == T_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DEQ: begin
                    count <= count - CW'(1);
                    space <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ack_out        = (state == ACK);
    assign enqueue_out    = (state == ENQ);
    assign dequeue_out    = (state == DEQ);
    assign queue_data_out = (state == ENQ) ? data_reg : '0;
    assign count_out      = count;
    assign space_out      = space;
    assign underflow_err  = underflow;
    assign timeout_err    = timeout;

endmodule

// File: tb/tb_queue_xfer_ctrl.sv
// Self-checking bench for queue_xfer_ctrl: directed scenarios plus randomized
// transfers scored against a byte-queue occupancy model.
module tb_queue_xfer_ctrl;

    localparam int DEPTH       = 8;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 10;
    localparam int CW          = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              data_ready_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              dequeue_req_in = 1'b0;
    logic              ack_out;
    logic              space_out;
    logic              enqueue_out;
    logic              dequeue_out;
    logic [DATA_W-1:0] queue_data_out;
    logic [CW-1:0]     count_out;
    logic              underflow_err;
    logic              timeout_err;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] model_q[$];

    always #5 clock = ~clock;

    queue_xfer_ctrl #(
        .DEPTH       (DEPTH),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_ready_in  (data_ready_in),
        .data_in        (data_in),
        .ack_out        (ack_out),
        .space_out      (space_out),
        .dequeue_req_in (dequeue_req_in),
        .enqueue_out    (enqueue_out),
        .dequeue_out    (dequeue_out),
        .queue_data_out (queue_data_out),
        .count_out      (count_out),
        .underflow_err  (underflow_err),
        .timeout_err    (timeout_err)
    );

    // Structural invariants watched on every cycle outside reset.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            total++;
            if (enqueue_out === 1'b1 && dequeue_out === 1'b1) begin
                bad++;
                $display("[TB] FAIL strobe_overlap: enqueue_out=%b dequeue_out=%b, need not both 1", enqueue_out, dequeue_out);
            end
            total++;
            if (count_out > CW'(DEPTH)) begin
                bad++;
                $display("[TB] FAIL count_range: count_out=%0d, need <= %0d", count_out, DEPTH);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        data_ready_in  = 1'b0;
        dequeue_req_in = 1'b0;
        tick();
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] b, input string tag);
        data_in       = b;
        data_ready_in = 1'b1;
        tick();
        total++;
        if (enqueue_out !== 1'b1 || queue_data_out !== b) begin
            bad++;
            $display("[TB] FAIL %s_enq: enqueue_out=%b data=%h, need 1/%h", tag, enqueue_out, queue_data_out, b);
        end
        tick();
        total++;
        if (ack_out !== 1'b1 || enqueue_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_ack_rise: ack_out=%b enqueue_out=%b, need 1/0", tag, ack_out, enqueue_out);
        end
        data_ready_in = 1'b0;
        tick();
        total++;
        if (ack_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_ack_drop: ack_out=%b, need 0", tag, ack_out);
        end
    endtask

    task automatic do_dequeue(input string tag);
        bit seen;
        seen = 1'b0;
        dequeue_req_in = 1'b1;
        tick();
        dequeue_req_in = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (dequeue_out === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL %s_deq: dequeue_out never 1 within 4 cycles, need one pulse", tag);
        end
        tick();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        data_ready_in  = 1'b1;
        data_in        = 8'hFF;
        dequeue_req_in = 1'b0;
        tick();
        tick();
        total++;
        if ({ack_out, enqueue_out, dequeue_out, underflow_err, timeout_err} !== 5'b0 ||
            space_out !== 1'b1 || count_out !== '0 || queue_data_out !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: ack=%b enq=%b deq=%b uf=%b to=%b space=%b count=%0d data=%h, need 0/0/0/0/0/1/0/00",
                     ack_out, enqueue_out, dequeue_out, underflow_err, timeout_err, space_out, count_out, queue_data_out);
        end
        data_ready_in = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if (count_out !== '0 || ack_out !== 1'b0 || enqueue_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: count=%0d ack=%b enq=%b, need 0/0/0", count_out, ack_out, enqueue_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        send_byte(8'hA5, "single");
        total++;
        if (count_out !== CW'(1) || space_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_count: count=%0d space=%b, need 1/1", count_out, space_out);
        end
    endtask

    task automatic test_full();
        bit blocked_ok;
        bit seen;
        do_reset();
        for (int i = 1; i <= DEPTH; i++) send_byte(DATA_W'(i), "fill");
        total++;
        if (count_out !== CW'(DEPTH) || space_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_count: count=%0d space=%b, need %0d/0", count_out, space_out, DEPTH);
        end
        data_in       = 8'h09;
        data_ready_in = 1'b1;
        blocked_ok    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (enqueue_out !== 1'b0 || ack_out !== 1'b0) blocked_ok = 1'b0;
        end
        total++;
        if (!blocked_ok) begin
            bad++;
            $display("[TB] FAIL full_backpressure: enqueue/ack seen while full, need none");
        end
        dequeue_req_in = 1'b1;
        tick();
        dequeue_req_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (dequeue_out === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL full_deq: dequeue_out not seen, need one pulse");
        end
        tick();
        total++;
        if (count_out !== CW'(DEPTH - 1)) begin
            bad++;
            $display("[TB] FAIL full_after_deq: count=%0d, need %0d", count_out, DEPTH - 1);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (enqueue_out === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen || queue_data_out !== 8'h09) begin
            bad++;
            $display("[TB] FAIL full_refill: seen=%b data=%h, need 1/09", seen, queue_data_out);
        end
        tick();
        data_ready_in = 1'b0;
        tick();
        total++;
        if (count_out !== CW'(DEPTH) || space_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_final: count=%0d space=%b, need %0d/0", count_out, space_out, DEPTH);
        end
    endtask

    task automatic test_arbitration();
        // Near-full: dequeue must win
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) send_byte(DATA_W'(8'h30 + i), "arb_fill7");
        dequeue_req_in = 1'b1;
        tick();
        dequeue_req_in = 1'b0;
        data_in        = 8'h77;
        data_ready_in  = 1'b1;
        tick();
        total++;
        if (dequeue_out !== 1'b1 || enqueue_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL arb7_first: deq=%b enq=%b, need 1/0", dequeue_out, enqueue_out);
        end
        tick();
        total++;
        if (count_out !== CW'(DEPTH - 2)) begin
            bad++;
            $display("[TB] FAIL arb7_mid: count=%0d, need %0d", count_out, DEPTH - 2);
        end
        tick();
        total++;
        if (enqueue_out !== 1'b1 || queue_data_out !== 8'h77) begin
            bad++;
            $display("[TB] FAIL arb7_enq: enq=%b data=%h, need 1/77", enqueue_out, queue_data_out);
        end
        tick();
        data_ready_in = 1'b0;
        tick();
        total++;
        if (count_out !== CW'(DEPTH - 1)) begin
            bad++;
            $display("[TB] FAIL arb7_final: count=%0d, need %0d", count_out, DEPTH - 1);
        end

        // Mid occupancy: enqueue must win, dequeue follows
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(DATA_W'(8'h40 + i), "arb_fill3");
        dequeue_req_in = 1'b1;
        tick();
        dequeue_req_in = 1'b0;
        data_in        = 8'h88;
        data_ready_in  = 1'b1;
        tick();
        total++;
        if (enqueue_out !== 1'b1 || dequeue_out !== 1'b0 || queue_data_out !== 8'h88) begin
            bad++;
            $display("[TB] FAIL arb3_first: enq=%b deq=%b data=%h, need 1/0/88", enqueue_out, dequeue_out, queue_data_out);
        end
        tick();
        total++;
        if (count_out !== CW'(4)) begin
            bad++;
            $display("[TB] FAIL arb3_mid: count=%0d, need 4", count_out);
        end
        data_ready_in = 1'b0;
        tick();
        tick();
        total++;
        if (dequeue_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL arb3_deq: deq=%b, need 1", dequeue_out);
        end
        tick();
        total++;
        if (count_out !== CW'(3)) begin
            bad++;
            $display("[TB] FAIL arb3_final: count=%0d, need 3", count_out);
        end
    endtask

    task automatic test_underflow();
        bit no_deq;
        do_reset();
        dequeue_req_in = 1'b1;
        tick();
        dequeue_req_in = 1'b0;
        no_deq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dequeue_out !== 1'b0) no_deq = 1'b0;
        end
        total++;
        if (!no_deq || underflow_err !== 1'b1 || count_out !== '0) begin
            bad++;
            $display("[TB] FAIL underflow_flag: no_deq=%b uf=%b count=%0d, need 1/1/0", no_deq, underflow_err, count_out);
        end
        send_byte(8'h12, "underflow_send");
        total++;
        if (underflow_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL underflow_sticky: uf=%b, need 1", underflow_err);
        end
        do_reset();
        total++;
        if (underflow_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL underflow_clear: uf=%b, need 0", underflow_err);
        end
    endtask

    task automatic test_timeout();
        bit ack_ok;
        bit quiet;
        do_reset();
        data_in       = 8'h3C;
        data_ready_in = 1'b1;
        tick();
        total++;
        if (enqueue_out !== 1'b1 || queue_data_out !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL timeout_enq: enq=%b data=%h, need 1/3c", enqueue_out, queue_data_out);
        end
        ack_ok = 1'b1;
        for (int i = 0; i < ACK_TIMEOUT; i++) begin
            tick();
            if (ack_out !== 1'b1 || timeout_err !== 1'b0) ack_ok = 1'b0;
        end
        total++;
        if (!ack_ok) begin
            bad++;
            $display("[TB] FAIL timeout_ack_window: ack/timeout wrong during %0d ACK cycles", ACK_TIMEOUT);
        end
        tick();
        total++;
        if (ack_out !== 1'b0 || timeout_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_fire: ack=%b to=%b, need 0/1", ack_out, timeout_err);
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (enqueue_out !== 1'b0 || ack_out !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("[TB] FAIL timeout_rearm: byte re-captured before ready dropped");
        end
        data_ready_in = 1'b0;
        tick();
        send_byte(8'h4D, "timeout_resend");
        total++;
        if (count_out !== CW'(2) || timeout_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_final: count=%0d to=%b, need 2/1", count_out, timeout_err);
        end
    endtask

    task automatic test_reset_mid_ack();
        int deq_pulses;
        do_reset();
        send_byte(8'h11, "midack_fill");
        send_byte(8'h22, "midack_fill");
        data_in       = 8'h33;
        data_ready_in = 1'b1;
        tick();
        tick();
        total++;
        if (ack_out !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midack_in_ack: ack=%b, need 1", ack_out);
        end
        dequeue_req_in = 1'b1;
        reset          = 1'b1;
        tick();
        total++;
        if (ack_out !== 1'b0 || count_out !== '0) begin
            bad++;
            $display("[TB] FAIL midack_abort: ack=%b count=%0d, need 0/0", ack_out, count_out);
        end
        reset   = 1'b0;
        data_in = 8'h5A;
        tick();
        total++;
        if (enqueue_out !== 1'b1 || queue_data_out !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL midack_enq: enq=%b data=%h, need 1/5a", enqueue_out, queue_data_out);
        end
        tick();
        data_ready_in = 1'b0;
        deq_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dequeue_out === 1'b1) deq_pulses++;
        end
        total++;
        if (deq_pulses != 1 || count_out !== '0 || underflow_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midack_one_request: pulses=%0d count=%0d uf=%b, need 1/0/0", deq_pulses, count_out, underflow_err);
        end
        dequeue_req_in = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] b;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if (model_q.size() < DEPTH && (model_q.size() == 0 || $urandom_range(0, 1) == 0)) begin
                b = DATA_W'($urandom);
                send_byte(b, "rand_send");
                model_q.push_back(b);
            end else begin
                do_dequeue("rand_deq");
                void'(model_q.pop_front());
            end
            total++;
            if (count_out !== CW'(model_q.size()) || space_out !== (model_q.size() != DEPTH)) begin
                bad++;
                $display("[TB] FAIL rand_occupancy: count=%0d space=%b, need %0d/%b",
                         count_out, space_out, model_q.size(), (model_q.size() != DEPTH));
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_arbitration();
        test_underflow();
        test_timeout();
        test_reset_mid_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
